// File: rtl/carfield_l2_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : carfield_l2_sched_pkg
//  Brief    : Shared types and helpers for the Carfield L2 dual-port scheduler
//             (port selector enum, response metadata, address decode).
//  Revision : 1.0 - initial release
// ============================================================================
package carfield_l2_sched_pkg;

    // Width of the requester id carried through the response pipelines.
    // It limits the number of requesters to 256.
    localparam int unsigned c_ID_W = 8;

    // Default geometry of one L2 port and the matching offset width.
    localparam logic [63:0] c_L2_PORT_SIZE   = 64'h0002_0000;
    localparam int unsigned c_L2_PORT_ADDR_W = $clog2(c_L2_PORT_SIZE);

    typedef enum logic [1:0] {
        PORT0    = 2'd0,
        PORT1    = 2'd1,
        PORT_ERR = 2'd2
    } port_sel_e;

    typedef struct packed {
        logic              valid;
        logic [c_ID_W-1:0] id;
        logic              we;
    } rsp_meta_t;

    // Map a byte address to port 0, port 1 or the error path.
    function automatic port_sel_e decode_port(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] size
    );
        port_sel_e sel;
        sel = PORT_ERR;
        if ((addr >= base) && (addr < base + size)) begin
            sel = PORT0;
        end else if ((addr >= base + size) && (addr < base + (size << 1))) begin
            sel = PORT1;
        end
        return sel;
    endfunction

endpackage : carfield_l2_sched_pkg
`default_nettype wire

// File: rtl/carfield_l2_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : carfield_l2_rr_arb
//  Brief    : NUM_REQ-way round-robin arbiter. The grant goes to the first
//             requester at or after the pointer; the pointer then moves to
//             grantee+1 and holds when nothing is granted.
//  Revision : 1.0 - initial release
// ============================================================================
module carfield_l2_rr_arb
    import carfield_l2_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [c_IDX_W-1:0] o_gnt_id
);

    logic [c_IDX_W-1:0] r_ptr;
    logic               w_found;
    int                 w_idx;

    // Scan requesters starting at the pointer and pick the first one found.
    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % int'(NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_gnt[w_idx]   = 1'b1;
                o_gnt_id       = c_IDX_W'(w_idx);
            end
        end
    end

    // Advance the pointer past the grantee, wrapping at NUM_REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (o_gnt_id == c_IDX_W'(NUM_REQ - 1)) ? '0 : o_gnt_id + 1'b1;
        end
    end

endmodule : carfield_l2_rr_arb
`default_nettype wire

// File: rtl/carfield_l2_dual_port_sched.sv
`default_nettype none
// ============================================================================
//  Module   : carfield_l2_dual_port_sched
//  Brief    : Shares the two L2 SRAM ports between NUM_REQ requesters.
//             Decodes each address to a port, arbitrates each port
//             round-robin and returns fixed-latency responses to the issuer.
//             Out-of-range requests take an error path of equal latency.
//  Config   : CARFIELD_L2_SCHED_PERF_EN enables per-port conflict counters.
//  Revision : 1.0 - initial release
// ============================================================================
module carfield_l2_dual_port_sched
    import carfield_l2_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = 4,
    parameter  int unsigned ADDR_WIDTH   = 48,
    parameter  int unsigned DATA_WIDTH   = 64,
    parameter  logic [63:0] L2_BASE      = 64'h7800_0000,
    parameter  logic [63:0] L2_PORT_SIZE = 64'h0002_0000,
    parameter  int unsigned MEM_LATENCY  = 1,
    localparam int unsigned c_BE_W       = DATA_WIDTH / 8,
    localparam int unsigned c_WADDR_W    = $clog2(L2_PORT_SIZE) - $clog2(DATA_WIDTH / 8)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*c_BE_W-1:0]     req_be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [NUM_REQ-1:0]            rerr_o,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]                    mem_req_o,
    output logic [2*c_WADDR_W-1:0]        mem_addr_o,
    output logic [1:0]                    mem_we_o,
    output logic [2*c_BE_W-1:0]           mem_be_o,
    output logic [2*DATA_WIDTH-1:0]       mem_wdata_o,
    input  logic [2*DATA_WIDTH-1:0]       mem_rdata_i,
    input  logic                          perf_clr_i,
    output logic [63:0]                   perf_conflict_o
);

    localparam int unsigned c_IDX_W    = $clog2(NUM_REQ);
    localparam int unsigned c_BYTE_OFF = $clog2(c_BE_W);

    port_sel_e          w_sel [NUM_REQ];
    logic [NUM_REQ-1:0] w_err_req;
    logic [NUM_REQ-1:0] w_port_gnt [2];
    rsp_meta_t          w_rsp [2];
    logic [NUM_REQ-1:0] r_err_pipe [MEM_LATENCY];

    // Address decode per requester; requests are masked while in reset so
    // that no grant or port access leaks out.
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            w_sel[r]     = decode_port(64'(req_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH]),
                                       L2_BASE, L2_PORT_SIZE);
            w_err_req[r] = rst_ni && req_i[r] && (w_sel[r] == PORT_ERR);
        end
    end

    // Each requester targets one port at most, so OR-ing is safe.
    assign gnt_o = w_err_req | w_port_gnt[0] | w_port_gnt[1];

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam port_sel_e c_SEL = (p == 0) ? PORT0 : PORT1;

        logic [NUM_REQ-1:0]    w_req;
        logic [NUM_REQ-1:0]    w_gnt;
        logic [c_IDX_W-1:0]    w_gnt_id;
        logic                  w_any;
        logic [c_WADDR_W-1:0]  w_addr;
        logic                  w_we;
        logic [c_BE_W-1:0]     w_be;
        logic [DATA_WIDTH-1:0] w_wdata;
        rsp_meta_t             r_pipe [MEM_LATENCY];

        // Collect the requesters whose address falls into this port.
        always_comb begin
            for (int r = 0; r < NUM_REQ; r++) begin
                w_req[r] = rst_ni && req_i[r] && (w_sel[r] == c_SEL);
            end
        end

        carfield_l2_rr_arb #(
            .NUM_REQ (NUM_REQ)
        ) u_arb (
            .clk      (clk_i),
            .rst_n    (rst_ni),
            .i_req    (w_req),
            .o_gnt    (w_gnt),
            .o_gnt_id (w_gnt_id)
        );

        // Forward the grantee's command; the word offset is a plain slice
        // because the port base is aligned to the port size.
        always_comb begin
            w_addr  = '0;
            w_we    = 1'b0;
            w_be    = '0;
            w_wdata = '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (w_gnt[r]) begin
                    w_addr  = req_addr_i[r*ADDR_WIDTH + c_BYTE_OFF +: c_WADDR_W];
                    w_we    = req_we_i[r];
                    w_be    = req_be_i[r*c_BE_W +: c_BE_W];
                    w_wdata = req_wdata_i[r*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end

        assign w_any                                  = |w_gnt;
        assign w_port_gnt[p]                          = w_gnt;
        assign mem_req_o[p]                           = w_any;
        assign mem_addr_o[p*c_WADDR_W +: c_WADDR_W]   = w_addr;
        assign mem_we_o[p]                            = w_we;
        assign mem_be_o[p*c_BE_W +: c_BE_W]           = w_be;
        assign mem_wdata_o[p*DATA_WIDTH +: DATA_WIDTH] = w_wdata;

        // Track who was granted and whether it was a write until the SRAM
        // data shows up MEM_LATENCY cycles later.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int s = 0; s < MEM_LATENCY; s++) begin
                    r_pipe[s] <= '0;
                end
            end else begin
                r_pipe[0].valid <= w_any;
                r_pipe[0].id    <= c_ID_W'(w_gnt_id);
                r_pipe[0].we    <= w_we;
                for (int s = 1; s < MEM_LATENCY; s++) begin
                    r_pipe[s] <= r_pipe[s-1];
                end
            end
        end

        assign w_rsp[p] = r_pipe[MEM_LATENCY-1];
    end

    // Error responses: several requesters may miss in the same cycle, so
    // each stage keeps a requester mask rather than a single id.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < MEM_LATENCY; s++) begin
                r_err_pipe[s] <= '0;
            end
        end else begin
            r_err_pipe[0] <= w_err_req;
            for (int s = 1; s < MEM_LATENCY; s++) begin
                r_err_pipe[s] <= r_err_pipe[s-1];
            end
        end
    end

    // Steer port responses and error responses back to their requesters.
    always_comb begin
        rvalid_o = r_err_pipe[MEM_LATENCY-1];
        rerr_o   = r_err_pipe[MEM_LATENCY-1];
        rdata_o  = '0;
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (w_rsp[p].valid && (w_rsp[p].id == c_ID_W'(r))) begin
                    rvalid_o[r] = 1'b1;
                    if (!w_rsp[p].we) begin
                        rdata_o[r*DATA_WIDTH +: DATA_WIDTH] =
                            mem_rdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

`ifdef CARFIELD_L2_SCHED_PERF_EN
    logic [31:0] r_conflict [2];
    logic [1:0]  w_conflict;

    // A conflict is any cycle where two or more requesters want the port.
    always_comb begin
        w_conflict = '0;
        for (int p = 0; p < 2; p++) begin
            int w_cnt;
            w_cnt = 0;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (req_i[r] && (w_sel[r] == ((p == 0) ? PORT0 : PORT1))) begin
                    w_cnt = w_cnt + 1;
                end
            end
            w_conflict[p] = (w_cnt >= 2);
        end
    end

    // Saturating counters; a clear overrides a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_conflict[0] <= '0;
            r_conflict[1] <= '0;
        end else if (perf_clr_i) begin
            r_conflict[0] <= '0;
            r_conflict[1] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_conflict[p] && (r_conflict[p] != '1)) begin
                    r_conflict[p] <= r_conflict[p] + 32'd1;
                end
            end
        end
    end

    assign perf_conflict_o = {r_conflict[1], r_conflict[0]};
`else
    logic w_unused_perf_clr;

    assign w_unused_perf_clr = perf_clr_i;
    assign perf_conflict_o   = '0;
`endif

endmodule : carfield_l2_dual_port_sched
`default_nettype wire

// File: tb/tb_carfield_l2_dual_port_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_carfield_l2_dual_port_sched
//  Brief    : Directed, table-driven bench for carfield_l2_dual_port_sched
//             with hand-written reset, write/read and perf-clear sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_carfield_l2_dual_port_sched;

    localparam logic [47:0] P0   = 48'h7800_0000;
    localparam logic [47:0] P1   = 48'h7802_0000;
    localparam logic [47:0] ERRA = 48'h1000_0000;
    localparam logic [63:0] D0   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1   = 64'hFEDC_BA98_7654_3210;
`ifdef CARFIELD_L2_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_ni;
    logic [3:0]   req_i;
    logic [191:0] req_addr_i;
    logic [3:0]   req_we_i;
    logic [31:0]  req_be_i;
    logic [255:0] req_wdata_i;
    logic [3:0]   gnt_o, rvalid_o, rerr_o;
    logic [255:0] rdata_o;
    logic [1:0]   mem_req_o, mem_we_o;
    logic [27:0]  mem_addr_o;
    logic [15:0]  mem_be_o;
    logic [127:0] mem_wdata_o;
    logic [127:0] mem_rdata_i;
    logic         perf_clr_i;
    logic [63:0]  perf_conflict_o;

    int tests = 0;
    int fails = 0;

    // Port-0 SRAM model used for the write/read sequence.
    logic        use_model = 1'b0;
    logic [63:0] model_mem [16384];
    logic [63:0] model_rd;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req_o[0]) begin
            if (mem_we_o[0]) begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_be_o[b]) model_mem[mem_addr_o[13:0]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
                end
            end
            model_rd <= model_mem[mem_addr_o[13:0]];
        end
    end

    assign mem_rdata_i = {D1, (use_model ? model_rd : D0)};

    carfield_l2_dual_port_sched dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .req_i           (req_i),
        .req_addr_i      (req_addr_i),
        .req_we_i        (req_we_i),
        .req_be_i        (req_be_i),
        .req_wdata_i     (req_wdata_i),
        .gnt_o           (gnt_o),
        .rvalid_o        (rvalid_o),
        .rerr_o          (rerr_o),
        .rdata_o         (rdata_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rdata_i     (mem_rdata_i),
        .perf_clr_i      (perf_clr_i),
        .perf_conflict_o (perf_conflict_o)
    );

    typedef struct {
        logic [3:0]       req;
        logic [3:0][47:0] addr;
        logic [3:0]       gnt;
        logic [1:0]       mreq;
        logic [13:0]      ma0;
        logic [13:0]      ma1;
        logic [3:0]       err;
        logic [7:0]       src;   // per requester: 1 = port0 data, 2 = port1 data, 0 = zero
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [3:0] req,
                        input logic [47:0] a0, input logic [47:0] a1,
                        input logic [47:0] a2, input logic [47:0] a3,
                        input logic [3:0] gnt, input logic [1:0] mreq,
                        input logic [13:0] ma0, input logic [13:0] ma1,
                        input logic [3:0] err, input logic [7:0] src);
        vecs[i].req  = req;
        vecs[i].addr = {a3, a2, a1, a0};
        vecs[i].gnt  = gnt;
        vecs[i].mreq = mreq;
        vecs[i].ma0  = ma0;
        vecs[i].ma1  = ma1;
        vecs[i].err  = err;
        vecs[i].src  = src;
    endtask

    task automatic check_rsp(input logic [3:0] g, input logic [3:0] e, input logic [7:0] src);
        logic [63:0] exp;
        chk("rvalid", 64'(rvalid_o), 64'(g));
        chk("rerr", 64'(rerr_o), 64'(e));
        for (int r = 0; r < 4; r++) begin
            if (g[r]) begin
                exp = (src[2*r +: 2] == 2'd1) ? D0 : (src[2*r +: 2] == 2'd2) ? D1 : 64'd0;
                chk($sformatf("rdata%0d", r), rdata_o[r*64 +: 64], exp);
            end
        end
    endtask

    task automatic idle_inputs();
        req_i       = '0;
        req_addr_i  = '0;
        req_we_i    = '0;
        req_be_i    = '0;
        req_wdata_i = '0;
        perf_clr_i  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] pg, pe;
        logic [7:0] ps;

        // ---- stimulus table (hand-computed expectations) ----
        for (int k = 0; k < 8; k++) begin
            setv(k, 4'hF, P0, P0 + 48'h100, P0 + 48'h200, P0 + 48'h300,
                 4'(1 << (k % 4)), 2'b01, 14'(32 * (k % 4)), 14'd0, 4'd0,
                 8'(1 << (2 * (k % 4))));
        end
        setv(8,  4'b0011, P0, P1 + 48'h8, '0, '0, 4'b0011, 2'b11, 14'd0, 14'd1, 4'd0, 8'b00_00_10_01);
        setv(9,  4'b0100, '0, '0, ERRA, '0, 4'b0100, 2'b00, 14'd0, 14'd0, 4'b0100, 8'd0);
        setv(10, 4'b1111, P1 + 48'h10, P0 + 48'h18, 48'h7804_0000, P1 + 48'h1FFF8,
             4'b1110, 2'b11, 14'd3, 14'h3FFF, 4'b0100, 8'b10_00_01_00);
        setv(11, 4'b0001, P1 + 48'h10, '0, '0, '0, 4'b0001, 2'b10, 14'd0, 14'd2, 4'd0, 8'b00_00_00_10);
        setv(12, 4'b0111, P0 + 48'h1FFF8, 48'h77FF_FFF8, P1, '0,
             4'b0111, 2'b11, 14'h3FFF, 14'd0, 4'b0010, 8'b00_10_00_01);
        setv(13, 4'b0000, '0, '0, '0, '0, 4'd0, 2'b00, 14'd0, 14'd0, 4'd0, 8'd0);

        // ---- reset behaviour with requests already asserted ----
        idle_inputs();
        rst_ni     = 1'b0;
        req_i      = 4'hF;
        req_addr_i = {P0, P0, P0, P0};
        repeat (2) @(negedge clk);
        chk("reset_gnt", 64'(gnt_o), 64'd0);
        chk("reset_mem_req", 64'(mem_req_o), 64'd0);
        chk("reset_rvalid", 64'(rvalid_o), 64'd0);
        chk("reset_perf", perf_conflict_o, 64'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        idle_inputs();

        // ---- first request after reset ----
        @(posedge clk); #1;
        req_i      = 4'b0001;
        req_addr_i = {48'd0, 48'd0, 48'd0, P0 + 48'h10};
        @(negedge clk);
        chk("first_gnt", 64'(gnt_o), 64'd1);
        chk("first_mem_req", 64'(mem_req_o), 64'd1);
        chk("first_mem_addr0", 64'(mem_addr_o[13:0]), 64'd2);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check_rsp(4'b0001, 4'b0000, 8'b01);

        do_reset();

        // ---- table-driven vectors ----
        pg = '0; pe = '0; ps = '0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            req_i      = vecs[i].req;
            req_addr_i = vecs[i].addr;
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), 64'(gnt_o), 64'(vecs[i].gnt));
            chk($sformatf("v%0d_mem_req", i), 64'(mem_req_o), 64'(vecs[i].mreq));
            if (vecs[i].mreq[0]) chk($sformatf("v%0d_mem_addr0", i), 64'(mem_addr_o[13:0]), 64'(vecs[i].ma0));
            if (vecs[i].mreq[1]) chk($sformatf("v%0d_mem_addr1", i), 64'(mem_addr_o[27:14]), 64'(vecs[i].ma1));
            check_rsp(pg, pe, ps);
            if (i == 8) chk("perf0_after_8", 64'(perf_conflict_o[31:0]), PERF ? 64'd8 : 64'd0);
            pg = vecs[i].gnt; pe = vecs[i].err; ps = vecs[i].src;
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check_rsp(pg, pe, ps);
        chk("perf_total", perf_conflict_o, PERF ? {32'd1, 32'd8} : 64'd0);

        // ---- clear wins over a same-cycle conflict ----
        @(posedge clk); #1;
        perf_clr_i = 1'b1;
        req_i      = 4'b0011;
        req_addr_i = {48'd0, 48'd0, P0, P0};
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("perf_clear", perf_conflict_o, 64'd0);

        // ---- write then read the same word from requester 3 ----
        use_model = 1'b1;
        @(posedge clk); #1;
        req_i       = 4'b1000;
        req_addr_i  = {P0 + 48'h40, 48'd0, 48'd0, 48'd0};
        req_we_i    = 4'b1000;
        req_be_i    = {8'hFF, 24'd0};
        req_wdata_i = {64'h0000_0000_DEAD_BEEF, 192'd0};
        @(negedge clk);
        chk("wr_gnt", 64'(gnt_o), 64'b1000);
        chk("wr_mem_we", 64'(mem_we_o), 64'b01);
        chk("wr_mem_be", 64'(mem_be_o[7:0]), 64'hFF);
        chk("wr_mem_wdata", mem_wdata_o[63:0], 64'hDEAD_BEEF);
        chk("wr_mem_addr0", 64'(mem_addr_o[13:0]), 64'd8);
        @(posedge clk); #1;
        req_we_i = 4'b0000;
        @(negedge clk);
        chk("rd_gnt", 64'(gnt_o), 64'b1000);
        chk("wr_rsp_rvalid", 64'(rvalid_o), 64'b1000);
        chk("wr_rsp_rdata", rdata_o[255:192], 64'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("rd_rsp_rvalid", 64'(rvalid_o), 64'b1000);
        chk("rd_rsp_rerr", 64'(rerr_o), 64'd0);
        chk("rd_rsp_rdata", rdata_o[255:192], 64'hDEAD_BEEF);
        use_model = 1'b0;

        // ---- reset with three responses in flight ----
        @(posedge clk); #1;
        req_i      = 4'b1111;
        req_addr_i = {P0 + 48'h8, ERRA, P1, P0};
        @(negedge clk);
        chk("inflight_gnt", 64'(gnt_o), 64'b0111);
        @(posedge clk); #1;
        rst_ni = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_perf", perf_conflict_o, 64'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("post_rst_rvalid", 64'(rvalid_o), 64'd0);
        @(posedge clk); #1;
        req_i      = 4'hF;
        req_addr_i = {P0 + 48'h300, P0 + 48'h200, P0 + 48'h100, P0};
        @(negedge clk);
        chk("ptr_restart_gnt", 64'(gnt_o), 64'b0001);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("ptr_restart_rvalid", 64'(rvalid_o), 64'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_carfield_l2_dual_port_sched
`default_nettype wire
